// File: rtl/ifetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch stage: widths, constants,
// fetch-queue payload and fetch FSM states.
package ifetch_unit_pkg;

    localparam int unsigned CPU_XLEN = 32;
    localparam logic [CPU_XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [CPU_XLEN-1:0] instr;
        logic [CPU_XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head is shown
// combinationally from storage.
module ifetch_unit_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             empty;
    logic             full;
    logic             push_en;
    logic             pop_en;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop_en  = pop_i && !empty;
    assign push_en = push_i && (!full || pop_en);

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_q] <= data_i;
            end
            wr_q  <= wr_q + AW'(push_en);
            rd_q  <= rd_q + AW'(pop_en);
            cnt_q <= cnt_q + CW'(push_en) - CW'(pop_en);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues word reads on a req/gnt/rvalid bus under a
// shared queue+outstanding credit, buffers responses and drops stale ones on flush.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned XLEN  = CPU_XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            flushed_req_q, flushed_req_d;

    logic [CW-1:0]   iq_count;
    logic [CW-1:0]   pq_count;
    logic [CW:0]     credit_sum;
    fetch_entry_t    iq_head;
    fetch_entry_t    iq_push_data;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pc_aligned;
    logic            accept;
    logic            gnt_evt;
    logic            rsp_keep;
    logic            iq_pop;
    logic            pq_pop;

    assign credit_sum = (CW+1)'(iq_count) + (CW+1)'(outst_q);
    assign pc_ready_o = (state_q == IDLE) && (credit_sum < (CW+1)'(DEPTH)) && !flush_i;
    assign accept     = pc_valid_i && pc_ready_o;
    assign pc_aligned = {pc_i[XLEN-1:2], 2'b00};

    // Request goes out in the accept cycle; in REQ it is held until granted.
    assign imem_req_o  = accept || (state_q == REQ);
    assign imem_addr_o = accept ? pc_aligned : addr_q;
    assign gnt_evt     = imem_req_o && imem_gnt_i;

    // A response landing in the flush cycle is older than the flush: discard it.
    assign rsp_keep = imem_rvalid_i && (drop_q == '0) && !flush_i;
    assign pq_pop   = imem_rvalid_i && (pq_count != '0);
    assign iq_pop   = instr_valid_o && instr_ready_i;

    assign iq_push_data = '{instr: imem_rdata_i, pc: pend_pc};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        outst_d       = outst_q + CW'(gnt_evt) - CW'(imem_rvalid_i);
        drop_d        = drop_q;
        flushed_req_d = flushed_req_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = pc_aligned;
                    if (!imem_gnt_i) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A request stuck in REQ across a flush is added to drop when it is granted.
        if (flush_i) begin
            drop_d        = outst_q - CW'(imem_rvalid_i)
                          + CW'((state_q == REQ) && imem_gnt_i);
            flushed_req_d = (state_q == REQ) && !imem_gnt_i;
        end else begin
            drop_d = drop_q - CW'(imem_rvalid_i && (drop_q != '0))
                   + CW'(flushed_req_q && imem_gnt_i);
            if ((state_q == REQ) && imem_gnt_i) begin
                flushed_req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            outst_q       <= '0;
            drop_q        <= '0;
            flushed_req_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            outst_q       <= outst_d;
            drop_q        <= drop_d;
            flushed_req_q <= flushed_req_d;
        end
    end

    ifetch_unit_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (accept),
        .data_i  (pc_i),
        .pop_i   (pq_pop),
        .data_o  (pend_pc),
        .count_o (pq_count)
    );

    ifetch_unit_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .push_i  (rsp_keep),
        .data_i  (iq_push_data),
        .pop_i   (iq_pop),
        .data_o  (iq_head),
        .count_o (iq_count)
    );

    assign instr_valid_o = (iq_count != '0);
    assign instr_o       = iq_head.instr;
    assign instr_pc_o    = iq_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: the bench plays PC control, instruction
// memory and PC-gen cycle by cycle against hand-computed expectations.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    int vectors;
    int miscompares;

    ifetch_unit #(.XLEN(32), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .pc_ready_o    (pc_ready_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_valid_i    = 1'b0;
        flush_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_i = 32'h0; instr_ready_i = 1'b0; idle_inputs();
        tick(); tick();
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset.req got %0b exp 0", imem_req_o); end
        vectors++; if (imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset.addr got %h exp 0", imem_addr_o); end
        vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset.valid got %0b exp 0", instr_valid_o); end
        vectors++; if (instr_o !== 32'h0) begin miscompares++; $display("FAIL reset.instr got %h exp 0", instr_o); end
        vectors++; if (instr_pc_o !== 32'h0) begin miscompares++; $display("FAIL reset.pc got %h exp 0", instr_pc_o); end
        rst = 1'b0;
        tick();
        vectors++; if (pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset.pc_ready got %0b exp 1", pc_ready_o); end
    endtask

    task automatic test_single();
        pc_i = 32'h0; pc_valid_i = 1'b1; imem_gnt_i = 1'b1; #1;
        vectors++; if (imem_req_o !== 1'b1) begin miscompares++; $display("FAIL single.req got %0b exp 1", imem_req_o); end
        vectors++; if (imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL single.addr got %h exp 0", imem_addr_o); end
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; #1;
        vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL single.early_valid got %0b exp 0", instr_valid_o); end
        tick();
        idle_inputs(); #1;
        vectors++; if (instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL single.valid got %0b exp 1", instr_valid_o); end
        vectors++; if (instr_o !== 32'h0050_0093) begin miscompares++; $display("FAIL single.instr got %h exp 00500093", instr_o); end
        vectors++; if (instr_pc_o !== 32'h0) begin miscompares++; $display("FAIL single.pc got %h exp 0", instr_pc_o); end
        instr_ready_i = 1'b1;
        tick();
        vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL single.popped got %0b exp 0", instr_valid_o); end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_stream();
        instr_ready_i = 1'b1;
        pc_i = 32'h0; pc_valid_i = 1'b1; imem_gnt_i = 1'b1; #1;
        vectors++; if (pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL stream.rdy0 got %0b exp 1", pc_ready_o); end
        tick();
        pc_i = 32'h4; imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h0); #1;
        vectors++; if (pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL stream.rdy4 got %0b exp 1", pc_ready_o); end
        tick();
        // queue 1 + outstanding 1 reaches the credit limit
        pc_i = 32'h8; imem_gnt_i = 1'b0; imem_rdata_i = dat(32'h4); #1;
        vectors++; if (pc_ready_o !== 1'b0) begin miscompares++; $display("FAIL stream.credit got %0b exp 0", pc_ready_o); end
        vectors++; if (instr_pc_o !== 32'h0 || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL stream.e0 got pc %h v %0b exp 0 v 1", instr_pc_o, instr_valid_o); end
        vectors++; if (instr_o !== dat(32'h0)) begin miscompares++; $display("FAIL stream.d0 got %h exp %h", instr_o, dat(32'h0)); end
        tick();
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; #1;
        vectors++; if (pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL stream.rdy8 got %0b exp 1", pc_ready_o); end
        vectors++; if (instr_pc_o !== 32'h4 || instr_o !== dat(32'h4)) begin miscompares++; $display("FAIL stream.e1 got pc %h d %h exp 4", instr_pc_o, instr_o); end
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h8); #1;
        vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL stream.gap got %0b exp 0", instr_valid_o); end
        tick();
        idle_inputs(); #1;
        vectors++; if (instr_pc_o !== 32'h8 || instr_o !== dat(32'h8) || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL stream.e2 got pc %h d %h v %0b exp 8", instr_pc_o, instr_o, instr_valid_o); end
        tick();
        instr_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        instr_ready_i = 1'b0;
        pc_i = 32'h40; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
        tick();
        pc_i = 32'h44; imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h40); #1;
        vectors++; if (pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp.rdy44 got %0b exp 1", pc_ready_o); end
        tick();
        pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rdata_i = dat(32'h44); #1;
        vectors++; if (pc_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp.stall1 got %0b exp 0", pc_ready_o); end
        tick();
        idle_inputs(); #1;
        vectors++; if (pc_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp.stall2 got %0b exp 0", pc_ready_o); end
        vectors++; if (instr_pc_o !== 32'h40 || instr_o !== dat(32'h40)) begin miscompares++; $display("FAIL bp.head got pc %h d %h exp 40", instr_pc_o, instr_o); end
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0; #1;
        vectors++; if (pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp.release got %0b exp 1", pc_ready_o); end
        vectors++; if (instr_pc_o !== 32'h44 || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp.next got pc %h v %0b exp 44", instr_pc_o, instr_valid_o); end
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp.drain got %0b exp 0", instr_valid_o); end
    endtask

    task automatic test_gnt_delay();
        pc_i = 32'h12; pc_valid_i = 1'b1; imem_gnt_i = 1'b0; #1;
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin miscompares++; $display("FAIL gnt.issue got req %0b addr %h exp 1 10", imem_req_o, imem_addr_o); end
        for (int c = 0; c < 3; c++) begin
            tick();
            pc_valid_i = 1'b0; pc_i = 32'hFFFF_FFFF; imem_gnt_i = (c == 2); #1;
            vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin miscompares++; $display("FAIL gnt.hold%0d got req %0b addr %h exp 1 10", c, imem_req_o, imem_addr_o); end
            vectors++; if (pc_ready_o !== 1'b0) begin miscompares++; $display("FAIL gnt.busy%0d got %0b exp 0", c, pc_ready_o); end
        end
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h10); #1;
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL gnt.release got %0b exp 0", imem_req_o); end
        tick();
        idle_inputs(); #1;
        vectors++; if (instr_pc_o !== 32'h12 || instr_o !== dat(32'h10) || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL gnt.resp got pc %h d %h v %0b exp 12", instr_pc_o, instr_o, instr_valid_o); end
        instr_ready_i = 1'b1;
        tick(); tick();
        instr_ready_i = 1'b0;
        vectors++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin miscompares++; $display("FAIL gnt.single got v %0b req %0b exp 0 0", instr_valid_o, imem_req_o); end
    endtask

    task automatic test_flush();
        instr_ready_i = 1'b1;
        pc_i = 32'h20; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
        tick();
        pc_i = 32'h24;
        tick();
        idle_inputs(); flush_i = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h80; #1;
        vectors++; if (pc_ready_o !== 1'b0 || imem_req_o !== 1'b0) begin miscompares++; $display("FAIL flush.block got rdy %0b req %0b exp 0 0", pc_ready_o, imem_req_o); end
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h20); #1;
        vectors++; if (pc_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush.credit got %0b exp 0", pc_ready_o); end
        tick();
        imem_rdata_i = dat(32'h24); #1;
        vectors++; if (instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush.drop0 got %0b exp 0", instr_valid_o); end
        tick();
        idle_inputs(); pc_i = 32'h100; pc_valid_i = 1'b1; imem_gnt_i = 1'b1; #1;
        vectors++; if (pc_ready_o !== 1'b1 || instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush.drop1 got rdy %0b v %0b exp 1 0", pc_ready_o, instr_valid_o); end
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h100);
        tick();
        idle_inputs(); #1;
        vectors++; if (instr_pc_o !== 32'h100 || instr_o !== dat(32'h100) || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL flush.first got pc %h d %h v %0b exp 100", instr_pc_o, instr_o, instr_valid_o); end
        tick();
        instr_ready_i = 1'b0;
    endtask

    task automatic test_flush_req();
        instr_ready_i = 1'b1;
        pc_i = 32'h30; pc_valid_i = 1'b1; imem_gnt_i = 1'b0;
        tick();
        idle_inputs(); flush_i = 1'b1; #1;
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h30) begin miscompares++; $display("FAIL freq.hold got req %0b addr %h exp 1 30", imem_req_o, imem_addr_o); end
        tick();
        idle_inputs(); imem_gnt_i = 1'b1; #1;
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h30) begin miscompares++; $display("FAIL freq.gnt got req %0b addr %h exp 1 30", imem_req_o, imem_addr_o); end
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h30);
        tick();
        idle_inputs(); pc_i = 32'h200; pc_valid_i = 1'b1; imem_gnt_i = 1'b1; #1;
        vectors++; if (instr_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL freq.dropped got v %0b rdy %0b exp 0 1", instr_valid_o, pc_ready_o); end
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h200);
        tick();
        idle_inputs(); #1;
        vectors++; if (instr_pc_o !== 32'h200 || instr_o !== dat(32'h200) || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL freq.next got pc %h d %h v %0b exp 200", instr_pc_o, instr_o, instr_valid_o); end
        tick();
        instr_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        instr_ready_i = 1'b0;
        pc_i = 32'h60; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
        tick();
        idle_inputs(); imem_rvalid_i = 1'b1; imem_rdata_i = dat(32'h60);
        tick();
        idle_inputs(); pc_i = 32'h50; pc_valid_i = 1'b1;
        tick();
        idle_inputs(); #1;
        vectors++; if (imem_req_o !== 1'b1 || instr_valid_o !== 1'b1) begin miscompares++; $display("FAIL arst.pre got req %0b v %0b exp 1 1", imem_req_o, instr_valid_o); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL arst.now got req %0b v %0b exp 0 0", imem_req_o, instr_valid_o); end
        vectors++; if (instr_o !== 32'h0 || instr_pc_o !== 32'h0 || imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL arst.data got i %h pc %h a %h exp 0", instr_o, instr_pc_o, imem_addr_o); end
        vectors++; if (pc_ready_o !== 1'b1) begin miscompares++; $display("FAIL arst.credit got %0b exp 1", pc_ready_o); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin miscompares++; $display("FAIL arst.after got req %0b v %0b exp 0 0", imem_req_o, instr_valid_o); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_gnt_delay();
        test_flush();
        test_flush_req();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
